// File: rtl/pulse_divider_pkg.sv
// Shared helpers for the pulse divider: how a divide ratio splits into low and high phases.
// Pure elaboration-time arithmetic, no hardware of its own.
// Not applicable: no ports.
package pulse_divider_pkg;

    // Edges spent low per output period. The odd leftover edge goes to the high phase.
    function automatic int low_cnt_of(input int divide_by);
        return divide_by / 2;
    endfunction

    // Edges spent high per output period.
    function automatic int high_cnt_of(input int divide_by);
        return divide_by - (divide_by / 2);
    endfunction

endpackage

// File: rtl/pulse_divider.sv
// Integer pulse divider: counts enabled rising edges and outputs a DIVIDE_BY-period square wave.
// Latency: output is registered and changes on the enabled edge that crosses a phase boundary.
// Backpressure: none; enable=0 freezes counter and output, stretching the current period.
//
// Ports:
//   pulse_clock     sole clock, all state updates on its rising edge
//   external_reset  synchronous active-high reset, clears counter and output, beats enable
//   enable          count enable, one count per rising edge while high
//   divided_clock   divided output, straight from a flop (glitch-free)
module pulse_divider
    import pulse_divider_pkg::*;
#(
    parameter int DIVIDE_BY = 10,
    parameter int CNT_W     = $clog2(DIVIDE_BY)
) (
    input  logic pulse_clock,
    input  logic external_reset,
    input  logic enable,
    output logic divided_clock
);

    localparam int LOW_CNT  = low_cnt_of(DIVIDE_BY);
    localparam int HIGH_CNT = high_cnt_of(DIVIDE_BY);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE_BY - 1);
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(LOW_CNT);

    // A divide ratio below 2 has no low phase; reject it at elaboration.
    generate
        if (DIVIDE_BY < 2 || HIGH_CNT < LOW_CNT) begin : g_bad_divide
            $error("pulse_divider: DIVIDE_BY must be >= 2");
        end
    endgenerate

    // Declaration initialisers give a defined output before the first reset.
    logic [CNT_W-1:0] cnt_q = '0;
    logic             out_q = 1'b0;
    logic [CNT_W-1:0] cnt_d;
    logic             out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (enable) begin
            // Explicit wrap keeps the count in range for non power-of-two ratios.
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            // Output level is decided from the count being entered, so the flop
            // switches on the same edge the counter crosses the boundary.
            out_d = (cnt_d >= CNT_RISE);
        end
    end

    always_ff @(posedge pulse_clock) begin
        if (external_reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign divided_clock = out_q;

endmodule

// File: tb/tb_pulse_divider.sv
module tb_pulse_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic en  = 1'b0;
    logic out10, out7, out2;

    pulse_divider #(.DIVIDE_BY(10)) u_div10 (
        .pulse_clock(clk), .external_reset(rst), .enable(en), .divided_clock(out10));
    pulse_divider #(.DIVIDE_BY(7)) u_div7 (
        .pulse_clock(clk), .external_reset(rst), .enable(en), .divided_clock(out7));
    pulse_divider #(.DIVIDE_BY(2)) u_div2 (
        .pulse_clock(clk), .external_reset(rst), .enable(en), .divided_clock(out2));

    int vectors     = 0;
    int miscompares = 0;

    // Reference: number of enabled edges since the last reset.
    int n_edges = 0;

    typedef struct {
        logic rst;
        logic en;
        logic exp10;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic e, input logic x);
        vec_t v;
        v.rst   = r;
        v.en    = e;
        v.exp10 = x;
        tbl.push_back(v);
    endfunction

    // Output is high during the last ceil(d/2) edges of every d-edge period.
    function automatic logic model(input int d, input int edges);
        return ((edges % d) >= (d / 2)) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b, expected %0b (vector %0d, t=%0t)",
                     name, act, exp, vectors, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (vector %0d)", name, act, exp, vectors);
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        if (r)      n_edges = 0;
        else if (e) n_edges++;
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s/div10", tag), out10, model(10, n_edges));
        check($sformatf("%s/div7",  tag), out7,  model(7,  n_edges));
        check($sformatf("%s/div2",  tag), out2,  model(2,  n_edges));
    endtask

    initial begin
        logic [9:0] pat10;
        int highs7;
        int toggles2;
        int first_rise7;
        logic prev2;

        // Bit k: expected div-by-10 level after enabled edge k of a period.
        pat10 = 10'b1111100000;

        #1;
        check("powerup/div10", out10, 1'b0);
        check("powerup/div7",  out7,  1'b0);
        check("powerup/div2",  out2,  1'b0);

        // Idle before any reset: output must stay low.
        repeat (10) add(1'b0, 1'b0, 1'b0);
        // Reset together with enable: reset wins.
        add(1'b1, 1'b1, 1'b0);
        // Four full periods plus 7 edges, ending with out high and count 7.
        for (int k = 1; k <= 47; k++) add(1'b0, 1'b1, pat10[k % 10]);
        // One-cycle reset mid-high, then the rise 5 edges later.
        add(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) add(1'b0, 1'b1, pat10[k]);
        // Reset with enable low, then freeze at count 3 for 3 cycles.
        add(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) add(1'b0, 1'b1, pat10[k]);
        repeat (3) add(1'b0, 1'b0, 1'b0);
        for (int k = 4; k <= 7; k++) add(1'b0, 1'b1, pat10[k]);
        // Freeze while high, then finish the period and fall.
        repeat (2) add(1'b0, 1'b0, 1'b1);
        for (int k = 8; k <= 10; k++) add(1'b0, 1'b1, pat10[k % 10]);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en);
            check($sformatf("table[%0d]/div10", i), out10, tbl[i].exp10);
            check($sformatf("table[%0d]/div7",  i), out7,  model(7, n_edges));
            check($sformatf("table[%0d]/div2",  i), out2,  model(2, n_edges));
        end

        // Duty shape for odd and minimum ratios over two periods of 7.
        step(1'b1, 1'b0);
        highs7      = 0;
        toggles2    = 0;
        first_rise7 = 0;
        for (int k = 1; k <= 14; k++) begin
            prev2 = out2;
            step(1'b0, 1'b1);
            if (out7 === 1'b1) highs7++;
            if (out7 === 1'b1 && first_rise7 == 0) first_rise7 = k;
            if (out2 !== prev2) toggles2++;
        end
        check_int("div7 high cycles in 14", highs7, 8);
        check_int("div7 first rise edge", first_rise7, 3);
        check_int("div2 toggles in 14", toggles2, 14);

        // Random enable/reset traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
            check_model($sformatf("rand[%0d]", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
